// File: rtl/bram_boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// bram_boot_loader_pkg
//   Shared definitions for the blram boot loader: loader state encoding and
//   the byte counts of the header and data-word fields of a load frame.
// -----------------------------------------------------------------------------
package bram_boot_loader_pkg;

  // Loader state machine encoding.
  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,  // collecting ADDR[15:0] and CNT[15:0]
    ST_DATA  = 3'd1,  // collecting the 4 bytes of one data word
    ST_WRITE = 3'd2,  // single-cycle blram write of the assembled word
    ST_HOLD  = 3'd3,  // keeping the CPU in reset after the last write
    ST_RUN   = 3'd4   // CPU owns the blram write/address port
  } state_t;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

endpackage : bram_boot_loader_pkg

// File: rtl/bram_boot_loader.sv
// -----------------------------------------------------------------------------
// bram_boot_loader
//   Upstream stage of the blram program memory. Receives a big-endian byte
//   stream frame (ADDR[15:0], CNT[15:0], CNT x 32-bit words), writes the words
//   into consecutive blram addresses, keeps the CPU in reset while loading and
//   for CPU_RST_HOLD cycles afterwards, then hands the blram write/address port
//   to the CPU. A reload pulse in RUN starts a new frame.
//
// Ports
//   clk           in   1       system clock, rising edge
//   rst           in   1       asynchronous active-low reset
//   in_valid      in   1       byte stream valid
//   in_data       in   8       byte stream data
//   in_ready      out  1       byte accepted when in_valid & in_ready at posedge
//   reload        in   1       one-cycle pulse, restarts loading (RUN only)
//   cpu_wrEn      in   1       CPU write enable
//   cpu_addr      in   ADDR_W  CPU address
//   cpu_data      in   32      CPU write data
//   ram_we        out  1       blram write enable
//   ram_addr      out  ADDR_W  blram address
//   ram_wdata     out  32      blram write data
//   cpu_rst       out  1       active-high reset to the CPU
//   load_done     out  1       high in RUN
//   words_loaded  out  16      data words written in the current/last frame
// -----------------------------------------------------------------------------
module bram_boot_loader
  import bram_boot_loader_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int CPU_RST_HOLD = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  input  logic              cpu_wrEn,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic [15:0]       words_loaded
);

  localparam int         HOLD_W    = (CPU_RST_HOLD > 1) ? $clog2(CPU_RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CPU_RST_HOLD - 1);
  localparam logic [1:0] HDR_LAST  = 2'(HDR_BYTES - 1);
  localparam logic [1:0] WORD_LAST = 2'(WORD_BYTES - 1);

  state_t              state_q, state_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [31:0]         shift_q, shift_d;
  logic [ADDR_W-1:0]   ld_addr_q, ld_addr_d;     // next loader write address
  logic [15:0]         cnt_q, cnt_d;             // words still to write
  logic [15:0]         words_q, words_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;     // loader-side ram_addr, held after the write
  logic [31:0]         wr_data_q, wr_data_d;     // loader-side ram_wdata

  logic                accept;
  logic [31:0]         shift_next;
  logic                run;

  assign run        = (state_q == ST_RUN);
  assign in_ready   = (state_q == ST_HDR) || (state_q == ST_DATA);
  assign accept     = in_valid && in_ready;
  assign shift_next = {shift_q[23:0], in_data};

  assign cpu_rst      = !run;
  assign load_done    = run;
  assign words_loaded = words_q;

  // Port mux: the CPU drives blram only in RUN; otherwise the loader's
  // registered write signals are presented and the cpu_* inputs are ignored.
  assign ram_we    = run ? cpu_wrEn : (state_q == ST_WRITE);
  assign ram_addr  = run ? cpu_addr : wr_addr_q;
  assign ram_wdata = run ? cpu_data : wr_data_q;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    ld_addr_d  = ld_addr_q;
    cnt_d      = cnt_q;
    words_d    = words_q;
    hold_d     = hold_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    unique case (state_q)
      ST_HDR: begin
        if (accept) begin
          shift_d    = shift_next;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == HDR_LAST) begin
            byte_idx_d = 2'd0;
            // ADDR occupies the upper half of the header, CNT the lower half.
            ld_addr_d  = ADDR_W'(shift_next[31:16]);
            cnt_d      = shift_next[15:0];
            if (shift_next[15:0] == 16'd0) begin
              state_d = ST_HOLD;
              hold_d  = '0;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          shift_d    = shift_next;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == WORD_LAST) begin
            byte_idx_d = 2'd0;
            wr_addr_d  = ld_addr_q;
            wr_data_d  = shift_next;
            state_d    = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        ld_addr_d = ld_addr_q + 1'b1;  // wraps at 2^ADDR_W by width
        words_d   = words_q + 16'd1;
        cnt_d     = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (reload) begin
          state_d    = ST_HDR;
          words_d    = 16'd0;
          byte_idx_d = 2'd0;
        end
      end

      default: begin
        state_d    = ST_HDR;
        byte_idx_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_HDR;
      byte_idx_q <= 2'd0;
      shift_q    <= 32'd0;
      ld_addr_q  <= '0;
      cnt_q      <= 16'd0;
      words_q    <= 16'd0;
      hold_q     <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      ld_addr_q  <= ld_addr_d;
      cnt_q      <= cnt_d;
      words_q    <= words_d;
      hold_q     <= hold_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

endmodule : bram_boot_loader

// File: tb/tb_bram_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_bram_boot_loader
//   Self-checking bench for bram_boot_loader: loader writes are checked against
//   a scoreboard queue filled as frames are sent; RUN-mode port pass-through is
//   checked from a vector table; reset, hold length, gaps and address wrap are
//   covered by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_bram_boot_loader;

  localparam int ADDR_W = 14;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              reload;
  logic              cpu_wrEn;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              cpu_rst;
  logic              load_done;
  logic [15:0]       words_loaded;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t sb_q[$];

  typedef struct {
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0]       exp_data;
    logic              exp_rdy;
  } run_vec_t;

  run_vec_t run_tab[4];

  bram_boot_loader #(.ADDR_W(ADDR_W), .CPU_RST_HOLD(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .reload       (reload),
    .cpu_wrEn     (cpu_wrEn),
    .cpu_addr     (cpu_addr),
    .cpu_data     (cpu_data),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .cpu_rst      (cpu_rst),
    .load_done    (load_done),
    .words_loaded (words_loaded)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Loader-write monitor: every write while the CPU is held in reset must be
  // the next entry of the scoreboard.
  always @(negedge clk) begin
    if (rst && cpu_rst && ram_we) begin
      chk("in_ready_during_write", {31'd0, in_ready}, 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual addr=%h data=%h required=no write", ram_addr, ram_wdata);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("write_addr", {18'd0, ram_addr}, {18'd0, e.addr});
        chk("write_data", ram_wdata, e.data);
        $display("write addr=%h data=%h", ram_addr, ram_wdata);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    bit r;
    ok = 1'b0;
    if (gap) begin
      in_valid = 1'b0;
      in_data  = 8'hA5;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      ok = r;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout actual=not accepted required=accepted byte=%h", b);
    end
  endtask

  task automatic send_hdr(input logic [15:0] addr, input logic [15:0] cnt, input bit gap);
    send_byte(addr[15:8], gap);
    send_byte(addr[7:0], gap);
    send_byte(cnt[15:8], gap);
    send_byte(cnt[7:0], gap);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  // Counts negedges from now until cpu_rst is first seen low.
  task automatic run_wait(input string name, input int exp_n);
    int n;
    n = 0;
    for (int i = 1; i <= 100 && n == 0; i++) begin
      @(negedge clk);
      if (!cpu_rst) n = i;
    end
    chk(name, n, exp_n);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200 && !load_done; i++) @(negedge clk);
    chk(name, {31'd0, load_done}, 32'd1);
  endtask

  task automatic do_reload(input logic [ADDR_W-1:0] last_ld_addr);
    @(posedge clk);
    #1;
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    chk("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("reload_load_done", {31'd0, load_done}, 32'd0);
    chk("reload_words", {16'd0, words_loaded}, 32'd0);
    chk("reload_we_blocked", {31'd0, ram_we}, 32'd0);
    chk("reload_addr_held", {18'd0, ram_addr}, {18'd0, last_ld_addr});
    $display("reload cpu_rst=%b load_done=%b", cpu_rst, load_done);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    chk({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
    chk({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
    chk({tag, "_ram_addr"}, {18'd0, ram_addr}, 32'd0);
    chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    chk({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    // CPU drives a write throughout loading; it must never reach blram.
    cpu_wrEn = 1'b1;
    cpu_addr = 14'h1234;
    cpu_data = 32'hCAFEF00D;

    run_tab[0] = '{1'b1, 14'd50,    32'd7,         1'b1, 14'd50,    32'd7,         1'b0};
    run_tab[1] = '{1'b0, 14'd50,    32'd7,         1'b0, 14'd50,    32'd7,         1'b0};
    run_tab[2] = '{1'b1, 14'h3FFF,  32'hFFFFFFFF,  1'b1, 14'h3FFF,  32'hFFFFFFFF,  1'b0};
    run_tab[3] = '{1'b1, 14'h0155,  32'h12345678,  1'b1, 14'h0155,  32'h12345678,  1'b0};

    #1;
    chk_reset_outputs("por");
    $display("reset in_ready=%b cpu_rst=%b", in_ready, cpu_rst);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: basic two-word frame, back-to-back bytes
    sb_q.push_back('{14'h0000, 32'h901901F5});
    sb_q.push_back('{14'h0001, 32'h809601F4});
    send_hdr(16'h0000, 16'h0002, 1'b0);
    send_word(32'h901901F5, 1'b0);
    send_word(32'h809601F4, 1'b0);
    @(negedge clk);
    chk("t1_we_latency", {31'd0, ram_we}, 32'd1);
    run_wait("t1_hold_len", 11);
    chk("t1_words", {16'd0, words_loaded}, 32'd2);
    chk("t1_load_done", {31'd0, load_done}, 32'd1);
    chk("t1_sb_empty", sb_q.size(), 32'd0);
    $display("frame1 words=%0d load_done=%b", words_loaded, load_done);

    // 2: same frame with in_valid low every other cycle
    do_reload(14'h0001);
    sb_q.push_back('{14'h0000, 32'h901901F5});
    sb_q.push_back('{14'h0001, 32'h809601F4});
    send_hdr(16'h0000, 16'h0002, 1'b1);
    send_word(32'h901901F5, 1'b1);
    send_word(32'h809601F4, 1'b1);
    wait_done("t2_done");
    chk("t2_words", {16'd0, words_loaded}, 32'd2);
    chk("t2_sb_empty", sb_q.size(), 32'd0);
    $display("frame2 words=%0d", words_loaded);

    // 3: zero-count frame goes straight to HOLD
    do_reload(14'h0001);
    send_hdr(16'h01F4, 16'h0000, 1'b0);
    run_wait("t3_hold_len", 11);
    chk("t3_words", {16'd0, words_loaded}, 32'd0);
    $display("frame3 words=%0d", words_loaded);

    // 4: address wrap
    do_reload(14'h0001);
    sb_q.push_back('{14'h3FFF, 32'h11111111});
    sb_q.push_back('{14'h0000, 32'h22222222});
    send_hdr(16'h3FFF, 16'h0002, 1'b0);
    send_word(32'h11111111, 1'b0);
    send_word(32'h22222222, 1'b0);
    wait_done("t4_done");
    chk("t4_words", {16'd0, words_loaded}, 32'd2);
    chk("t4_sb_empty", sb_q.size(), 32'd0);
    $display("frame4 words=%0d", words_loaded);

    // 5: reset mid-word, then a fresh frame
    do_reload(14'h0000);
    send_hdr(16'h0010, 16'h0002, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    $display("midframe reset in_ready=%b cpu_rst=%b", in_ready, cpu_rst);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sb_q.push_back('{14'h0020, 32'hDEADBEEF});
    send_hdr(16'h0020, 16'h0001, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    wait_done("t5_done");
    chk("t5_words", {16'd0, words_loaded}, 32'd1);
    chk("t5_sb_empty", sb_q.size(), 32'd0);
    $display("frame5 words=%0d", words_loaded);

    // 6: RUN-mode pass-through table, bytes offered but refused
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      cpu_wrEn = run_tab[i].wr_en;
      cpu_addr = run_tab[i].addr;
      cpu_data = run_tab[i].data;
      #1;
      chk("run_we", {31'd0, ram_we}, {31'd0, run_tab[i].exp_we});
      chk("run_addr", {18'd0, ram_addr}, {18'd0, run_tab[i].exp_addr});
      chk("run_wdata", ram_wdata, run_tab[i].exp_data);
      chk("run_in_ready", {31'd0, in_ready}, {31'd0, run_tab[i].exp_rdy});
      $display("run vec %0d we=%b addr=%h data=%h", i, ram_we, ram_addr, ram_wdata);
    end
    in_valid = 1'b0;
    chk("t6_words_kept", {16'd0, words_loaded}, 32'd1);
    cpu_wrEn = 1'b1;
    cpu_addr = 14'd50;
    cpu_data = 32'd7;
    do_reload(14'h0020);

    chk("final_sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bram_boot_loader
